// File: rtl/add_sub_pipe.sv
// Pipelined adder/subtractor with status flags and valid/ready handshake.
// Optional saturation on signed overflow when ADD_SUB_PIPE_SAT_EN is defined (adds the sat port).
module add_sub_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef ADD_SUB_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             of,
    output logic             sf,
    output logic             zf,
    output logic             cf
);

    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("add_sub_pipe: illegal WIDTH/STAGES combination");
    end

    // Stage registers: stage k holds segments [0..k] of the result plus the skewed operands.
    logic             v_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] bx_q  [STAGES];
    logic [WIDTH-1:0] f_q   [STAGES];
    logic             c_q   [STAGES];
    logic             z_q   [STAGES];
    logic             sub_q [STAGES];
`ifdef ADD_SUB_PIPE_SAT_EN
    logic             sat_q [STAGES];
    logic             src_sat [STAGES];
`endif

    logic             of_q;
    logic             sf_q;
    logic             zf_q;
    logic             cf_q;

    logic             src_v   [STAGES];
    logic [WIDTH-1:0] src_a   [STAGES];
    logic [WIDTH-1:0] src_bx  [STAGES];
    logic [WIDTH-1:0] src_f   [STAGES];
    logic             src_c   [STAGES];
    logic             src_z   [STAGES];
    logic             src_sub [STAGES];

    logic [SEG:0]     seg_sum [STAGES];
    logic [WIDTH-1:0] nxt_f   [STAGES];
    logic             nxt_c   [STAGES];
    logic             nxt_z   [STAGES];

    logic             advance;
    logic             ovf;
    logic             clamp;
    logic [WIDTH-1:0] fin_f;

    assign advance = !v_q[LAST] || out_ready;

    // Stage inputs: stage 0 takes the port operands, later stages take the previous register.
    always_comb begin
        src_v[0]   = in_valid;
        src_a[0]   = a;
        src_bx[0]  = sub ? ~b : b;
        src_f[0]   = '0;
        src_c[0]   = cin ^ sub;
        src_z[0]   = 1'b1;
        src_sub[0] = sub;
`ifdef ADD_SUB_PIPE_SAT_EN
        src_sat[0] = sat;
`endif
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_v[k]   = v_q[k-1];
            src_a[k]   = a_q[k-1];
            src_bx[k]  = bx_q[k-1];
            src_f[k]   = f_q[k-1];
            src_c[k]   = c_q[k-1];
            src_z[k]   = z_q[k-1];
            src_sub[k] = sub_q[k-1];
`ifdef ADD_SUB_PIPE_SAT_EN
            src_sat[k] = sat_q[k-1];
`endif
        end
    end

    // One carry segment per stage.
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            seg_sum[k] = {1'b0, src_a[k][k*SEG +: SEG]}
                       + {1'b0, src_bx[k][k*SEG +: SEG]}
                       + (SEG+1)'(src_c[k]);
            nxt_f[k] = src_f[k];
            nxt_f[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
            nxt_c[k] = seg_sum[k][SEG];
            nxt_z[k] = src_z[k] && (seg_sum[k][SEG-1:0] == '0);
        end
    end

    // Final-stage overflow and optional clamp; clamp direction follows the operand sign.
    always_comb begin
        ovf   = (src_a[LAST][WIDTH-1] == src_bx[LAST][WIDTH-1]) &&
                (nxt_f[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
        clamp = 1'b0;
`ifdef ADD_SUB_PIPE_SAT_EN
        clamp = src_sat[LAST] && ovf;
`endif
        fin_f = nxt_f[LAST];
        if (clamp) begin
            fin_f = src_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // All stages shift together on advance; data only loads behind a valid op.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k]   <= 1'b0;
                a_q[k]   <= '0;
                bx_q[k]  <= '0;
                f_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                z_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
`ifdef ADD_SUB_PIPE_SAT_EN
                sat_q[k] <= 1'b0;
`endif
            end
            of_q <= 1'b0;
            sf_q <= 1'b0;
            zf_q <= 1'b0;
            cf_q <= 1'b0;
        end else if (advance) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= src_v[k];
                if (src_v[k]) begin
                    a_q[k]   <= src_a[k];
                    bx_q[k]  <= src_bx[k];
                    f_q[k]   <= (k == LAST) ? fin_f : nxt_f[k];
                    c_q[k]   <= nxt_c[k];
                    z_q[k]   <= nxt_z[k];
                    sub_q[k] <= src_sub[k];
`ifdef ADD_SUB_PIPE_SAT_EN
                    sat_q[k] <= src_sat[k];
`endif
                end
            end
            if (src_v[LAST]) begin
                of_q <= ovf;
                sf_q <= fin_f[WIDTH-1];
                zf_q <= nxt_z[LAST] && !clamp;
                cf_q <= nxt_c[LAST] ^ src_sub[LAST];
            end
        end
    end

    assign in_ready  = advance;
    assign out_valid = v_q[LAST];
    assign f         = f_q[LAST];
    assign cout      = c_q[LAST];
    assign of        = of_q;
    assign sf        = sf_q;
    assign zf        = zf_q;
    assign cf        = cf_q;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Scoreboard bench for add_sub_pipe (WIDTH=32, STAGES=2) with hand-computed vectors.
module tb_add_sub_pipe;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] f;
    logic         cout;
    logic         of;
    logic         sf;
    logic         zf;
    logic         cf;
`ifdef ADD_SUB_PIPE_SAT_EN
    logic         sat;
`endif

    always #5 clk = ~clk;

    add_sub_pipe #(.WIDTH(32), .STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
`ifdef ADD_SUB_PIPE_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .cout      (cout),
        .of        (of),
        .sf        (sf),
        .zf        (zf),
        .cf        (cf)
    );

    typedef struct packed {
        logic [W-1:0] f;
        logic         cout;
        logic         of;
        logic         sf;
        logic         zf;
        logic         cf;
    } res_t;

    res_t exp_q[$];
    res_t exp_r;
    res_t snap;
    logic held = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic res_t mk(input logic [W-1:0] rf, input logic rc, input logic ro,
                                input logic rs, input logic rz, input logic rcf);
        res_t r;
        r = {rf, rc, ro, rs, rz, rcf};
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: pop expected on every transfer; check stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else if (out_valid) begin
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_result: got f=%h, expected no result", f);
                end else begin
                    exp_r = exp_q.pop_front();
                    chk("f",    f,        exp_r.f);
                    chk("cout", W'(cout), W'(exp_r.cout));
                    chk("of",   W'(of),   W'(exp_r.of));
                    chk("sf",   W'(sf),   W'(exp_r.sf));
                    chk("zf",   W'(zf),   W'(exp_r.zf));
                    chk("cf",   W'(cf),   W'(exp_r.cf));
                end
                held = 1'b0;
            end else begin
                chk("in_ready_stall", W'(in_ready), '0);
                if (held) begin
                    chk("hold_f",     f, snap.f);
                    chk("hold_flags", W'({cout, of, sf, zf, cf}),
                        W'({snap.cout, snap.of, snap.sf, snap.zf, snap.cf}));
                end
                snap = {f, cout, of, sf, zf, cf};
                held = 1'b1;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic icin, input logic isub, input res_t e);
        int t = 0;
        a        = ia;
        b        = ib;
        cin      = icin;
        sub      = isub;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk(name, W'(exp_q.size()), '0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_out_valid"}, W'(out_valid), '0);
        chk({tag, "_in_ready"},  W'(in_ready),  W'(1'b1));
        chk({tag, "_f"},         f,             '0);
        chk({tag, "_flags"},     W'({cout, of, sf, zf, cf}), '0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
`ifdef ADD_SUB_PIPE_SAT_EN
        sat       = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;

        // Directed vectors, back-to-back with out_ready high.
        send(32'h0000_0001, 32'h7fff_ffff, 1'b0, 1'b0, mk(32'h8000_0000, 0, 1, 1, 0, 0));
        send(32'hffff_ffff, 32'h0000_0010, 1'b0, 1'b0, mk(32'h0000_000f, 1, 0, 0, 0, 1));
        send(32'hff0f_0000, 32'h00f0_ffff, 1'b1, 1'b0, mk(32'h0000_0000, 1, 0, 0, 1, 1));
        send(32'd12345678,  32'd12345680,  1'b0, 1'b1, mk(32'hffff_fffe, 0, 0, 1, 0, 1));
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(32'h7fff_ffff, 1, 1, 0, 0, 0));
        send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, mk(32'hffff_ffff, 0, 0, 1, 0, 1));
        drain("drain_directed");

        // Backpressure: 4 ops streamed while the consumer stalls for 3 cycles.
        @(posedge clk);
        #1;
        fork
            begin
                send(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, mk(32'h0000_0008, 0, 0, 0, 0, 0));
                send(32'h0000_000a, 32'h0000_0003, 1'b1, 1'b1, mk(32'h0000_0006, 1, 0, 0, 0, 0));
                send(32'h0000_ffff, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0001_0000, 0, 0, 0, 0, 0));
                send(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, mk(32'h0000_0000, 1, 0, 0, 1, 0));
            end
            begin
                int t = 0;
                while (!out_valid && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                if (!out_valid) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL bp_first_valid: got out_valid=0, expected 1 within 50 cycles");
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Reset mid-flight: two accepted ops must vanish.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, mk(32'h3333_3333, 0, 0, 0, 0, 0));
        send(32'h0000_0004, 32'h0000_0001, 1'b0, 1'b1, mk(32'h0000_0003, 1, 0, 0, 0, 0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_idle("midreset");
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send(32'h0000_0002, 32'h0000_0003, 1'b1, 1'b0, mk(32'h0000_0006, 0, 0, 0, 0, 0));
        drain("drain_after_reset");

`ifdef ADD_SUB_PIPE_SAT_EN
        sat = 1'b1;
        send(32'h7fff_ffff, 32'h0000_0001, 1'b0, 1'b0, mk(32'h7fff_ffff, 0, 1, 0, 0, 0));
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(32'h8000_0000, 1, 1, 1, 0, 0));
        sat = 1'b0;
        drain("drain_sat");
`endif

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/add_sub_pipe.md
Name: add_sub_pipe

Overview:
- Parametrised, pipelined adder/subtractor with status flags; next generation of the combinational 32-bit flag adder.
- Splits the carry chain into STAGES registered segments and adds subtract-with-borrow.
- Adds valid/ready handshaking so it can sit in the SPU execute path with backpressure.

Parameters:
- WIDTH, 32, operand/result width; must be ≥2.
- STAGES, 2, pipeline depth = number of carry segments; 1 ≤ STAGES ≤ WIDTH, WIDTH % STAGES == 0; SEG = WIDTH/STAGES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: F=A+B+cin; 1: F=A−B−cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- f  out  WIDTH  result.
- cout  out  1  raw carry out of MSB.
- of  out  1  signed overflow.
- sf  out  1  sign, f[WIDTH-1].
- zf  out  1  f == 0.
- cf  out  1  cout ^ sub (carry for add, borrow for sub).

Behaviour:
- Datapath: B' = sub ? ~b : b; c0 = cin ^ sub; {cout,f} = a + B' + c0.
- of = (a[MSB] == B'[MSB]) && (f[MSB] != a[MSB]).
- Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] using the registered carry from stage k−1.
  - Higher operand segments are skewed forward; lower result segments and per-segment zero bits are deskewed.
  - All of this travels with a per-stage valid bit.
- Flags come from the final-stage carry, the MSB segment and the AND of segment zero bits. All outputs are registered.
- Latency: exactly STAGES cycles from accepted input (in_valid && in_ready) to out_valid, with no stall.
- Throughput: 1 op/cycle.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance (combinational from out_valid and out_ready).
  - When advance=1, all stage registers shift together. A stage whose input is not valid loads valid=0, so bubbles propagate.
  - When advance=0, all stage registers and outputs hold and the input is not accepted.
  - Results are never dropped or duplicated.
  - out_valid && out_ready consumes the result. If the stage behind is valid, the next result appears in the same cycle edge.
- Outputs are held stable while out_valid=1 and out_ready=0.
- Reset: synchronous.
  - All valid bits → 0; f, cout, of, sf, zf, cf → 0; out_valid=0; in_ready=1 the cycle after reset.
  - Reset mid-operation discards all in-flight ops. Inputs presented during rst are ignored.
- STAGES=1: a single register stage with flags in that stage; latency 1.
- Wrap-around: the result is modulo 2^WIDTH. The overflow condition does not alter f except under the optional feature.

Optional Feature:
- Macro ADD_SUB_PIPE_SAT_EN.
- Defined: extra input port `sat` (1 bit), captured with the operands and travelling with them.
  - At the final stage, if sat=1 and of=1, f is clamped: positive overflow → 0111…1, negative overflow → 1000…0.
  - of, cout and cf report the unclamped operation; sf and zf reflect the clamped f.
- Undefined: no `sat` port; f always wraps.

Test Plan:
- WIDTH=32, STAGES=2, add: a=0x00000001, b=0x7fffffff, cin=0 → after 2 cycles f=0x80000000, of=1, sf=1, zf=0, cout=0, cf=0.
- Add: a=0xffffffff, b=0x00000010 → f=0x0000000f, cout=1, cf=1, of=0; a=0xff0f0000, b=0x00f0ffff, cin=1 → f=0x00000000, cout=1, zf=1.
- Sub: a=12345678, b=12345680, sub=1, cin=0 → f=0xfffffffe, cout=0, cf=1, sf=1, of=0; a=0x80000000, b=1, sub=1 → f=0x7fffffff, of=1.
- Backpressure: stream 4 back-to-back ops, hold out_ready=0 for 3 cycles after first out_valid → in_ready=0 during hold, outputs stable, all 4 results emerge in order with no loss or duplication.
- Reset mid-flight: accept 2 ops, assert rst for 1 cycle → out_valid=0 and all outputs 0 next cycle; neither op ever appears.
- With ADD_SUB_PIPE_SAT_EN, sat=1: a=0x7fffffff, b=1 → f=0x7fffffff, of=1; a=0x80000000, b=1, sub=1 → f=0x80000000, of=1.
